// File: rtl/edge_sched_pkg.sv
// Shared types and defaults for the edge-count scheduler: the FSM state
// encoding and default widths for the counter and the window length.
package edge_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WINDOW,
    SETTLE,
    REPORT
  } state_t;

  localparam int DEF_CW    = 32;
  localparam int DEF_WIN_W = 16;

endpackage

// File: rtl/edge_count_sched_if.sv
// Result port of the edge-count scheduler: one captured count pair per channel,
// handed over with a valid/ready handshake.
interface edge_count_sched_if
  import edge_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CW     = DEF_CW
);

  localparam int CH_W = $clog2(NUM_CH);

  logic            res_valid;
  logic            res_ready;
  logic [CH_W-1:0] res_ch;
  logic [CW-1:0]   res_pos;
  logic [CW-1:0]   res_neg;

  modport master (
    output res_valid, res_ch, res_pos, res_neg,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_ch, res_pos, res_neg,
    output res_ready
  );

endinterface

// File: rtl/edge_sched_timer.sv
// Loadable down-counter timing the CLEAR, WINDOW and SETTLE phases; tc is high
// while the count is zero, so loading N-1 on phase entry gives an N-cycle phase.
module edge_sched_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/edge_count_sched.sv
// Sweeps one shared edge_counter across the enabled input channels: clear,
// gate the channel in for win_len cycles, let the counts settle, then report.
module edge_count_sched
  import edge_sched_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CW         = DEF_CW,
  parameter int WIN_W      = DEF_WIN_W,
  parameter int CLR_CYC    = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [WIN_W-1:0]   win_len,
  input  logic [NUM_CH-1:0]  sig_in,
  output logic               cnt_reset,
  output logic               cnt_signal,
  input  logic [CW-1:0]      posedge_count,
  input  logic [CW-1:0]      negedge_count,
  edge_count_sched_if.master res,
  output logic               busy,
  output logic               done
);

  localparam int CH_W = $clog2(NUM_CH);

  state_t            state;
  logic [CH_W-1:0]   sel;
  logic [NUM_CH-1:0] mask_q;
  logic [WIN_W-1:0]  len_q;

  logic              first_found;
  logic [CH_W-1:0]   first_sel;
  logic              next_found;
  logic [CH_W-1:0]   next_sel;
  logic              handshake;
  logic              tmr_load;
  logic [WIN_W-1:0]  tmr_val;
  logic              tmr_tc;

  // Descending scans so the last hit is the lowest qualifying channel.
  always_comb begin
    first_found = 1'b0;
    first_sel   = '0;
    next_found  = 1'b0;
    next_sel    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        first_found = 1'b1;
        first_sel   = CH_W'(i);
      end
      if (mask_q[i] && (i > int'(sel))) begin
        next_found = 1'b1;
        next_sel   = CH_W'(i);
      end
    end
  end

  assign handshake = res.res_valid && res.res_ready;

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE: begin
        if (start && first_found) begin
          tmr_load = 1'b1;
          tmr_val  = WIN_W'(CLR_CYC - 1);
        end
      end
      CLEAR: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          tmr_val  = len_q - WIN_W'(1);
        end
      end
      WINDOW: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          tmr_val  = WIN_W'(SETTLE_CYC - 1);
        end
      end
      REPORT: begin
        if (handshake && next_found) begin
          tmr_load = 1'b1;
          tmr_val  = WIN_W'(CLR_CYC - 1);
        end
      end
      default: begin
      end
    endcase
  end

  edge_sched_timer #(
    .W (WIN_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // Abort outranks everything, including a handshake in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sel           <= '0;
      mask_q        <= '0;
      len_q         <= '0;
      cnt_reset     <= 1'b1;
      cnt_signal    <= 1'b0;
      res.res_valid <= 1'b0;
      res.res_ch    <= '0;
      res.res_pos   <= '0;
      res.res_neg   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        state         <= IDLE;
        res.res_valid <= 1'b0;
        cnt_reset     <= 1'b1;
        busy          <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt_reset <= 1'b1;
            if (start) begin
              mask_q <= ch_mask;
              len_q  <= (win_len == '0) ? WIN_W'(1) : win_len;
              if (first_found) begin
                sel   <= first_sel;
                state <= CLEAR;
                busy  <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
          CLEAR: begin
            cnt_signal <= sig_in[sel];
            if (tmr_tc) begin
              cnt_reset <= 1'b0;
              state     <= WINDOW;
            end
          end
          WINDOW: begin
            cnt_signal <= sig_in[sel];
            if (tmr_tc) begin
              state <= SETTLE;
            end
          end
          // cnt_signal is left untouched here so the counter sees no new edges.
          SETTLE: begin
            if (tmr_tc) begin
              res.res_pos   <= posedge_count;
              res.res_neg   <= negedge_count;
              res.res_ch    <= sel;
              res.res_valid <= 1'b1;
              state         <= REPORT;
            end
          end
          REPORT: begin
            if (handshake) begin
              res.res_valid <= 1'b0;
              cnt_reset     <= 1'b1;
              if (next_found) begin
                sel   <= next_sel;
                state <= CLEAR;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/edge_count_sched.md
Name: edge_count_sched

Overview:
- Time-multiplexes one shared edge_counter instance across NUM_CH asynchronous-origin input signals.
- For each enabled channel the block does four things in order:
  - clears the counter
  - gates the selected signal into it for a programmable window
  - waits for the counter outputs to settle
  - captures the posedge/negedge counts and presents them on a valid/ready result port
- Sits between the signal pins (already synchronised upstream) and the measurement/readout logic.

Parameters:
- NUM_CH, 4, number of input channels (2..16)
- CW, 32, edge_counter count width
- WIN_W, 16, width of the window-length input
- CLR_CYC, 2, cycles cnt_reset is held per channel
- SETTLE_CYC, 2, cycles between window end and count capture

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin one sweep; sampled only in IDLE
- abort  in  1  synchronous abort of the sweep in progress
- ch_mask  in  NUM_CH  channel enables; latched on accepted start
- win_len  in  WIN_W  window length in cycles; latched on accepted start
- sig_in  in  NUM_CH  synchronised input signals
- cnt_reset  out  1  active-high reset to edge_counter
- cnt_signal  out  1  signal to edge_counter
- posedge_count  in  CW  from edge_counter
- negedge_count  in  CW  from edge_counter
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_ch  out  $clog2(NUM_CH)  channel index of result
- res_pos  out  CW  captured posedge count
- res_neg  out  CW  captured negedge count
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at sweep completion

Behaviour:
- Reset values:
  - state=IDLE, cnt_reset=1, cnt_signal=0
  - res_valid=0, res_ch/res_pos/res_neg=0
  - busy=0, done=0
  - latched mask/len=0
- States: IDLE, CLEAR, WINDOW, SETTLE, REPORT.
- IDLE:
  - cnt_reset=1.
  - On start=1, latch ch_mask and win_len. A win_len of 0 is treated as 1.
  - If the latched mask is 0: pulse done on the next cycle and stay IDLE.
  - Otherwise select the lowest set bit and go to CLEAR.
- CLEAR:
  - cnt_reset=1 for exactly CLR_CYC cycles.
  - cnt_signal=sig_in[sel] registered, one cycle latency. Any glitch from the mux switch is absorbed while the counter is held in reset.
  - Then go to WINDOW.
- WINDOW:
  - cnt_reset=0 and cnt_signal continues tracking sig_in[sel] registered.
  - Lasts exactly win_len cycles, then go to SETTLE.
- SETTLE:
  - cnt_signal frozen at its last WINDOW value, so no further edges are counted. cnt_reset=0.
  - Lasts SETTLE_CYC cycles.
  - On the final SETTLE cycle, capture posedge_count/negedge_count into res_pos/res_neg, set res_ch=sel, assert res_valid, and go to REPORT.
- REPORT:
  - res_valid and the result fields stay stable until res_valid&&res_ready.
  - Handshake cycle:
    - res_valid drops next cycle.
    - Advance sel to the next higher set mask bit and go to CLEAR.
    - If no higher bit is set: pulse done for one cycle, return to IDLE, and set cnt_reset=1.
- Handshake rules:
  - res_ready may be held high permanently; results are then emitted back-to-back per channel with no stall.
  - res_valid never deasserts without a handshake, except on abort or reset.
- Events ignored or dominated:
  - start while busy is ignored.
  - abort in any non-IDLE state: next cycle state=IDLE, res_valid=0, cnt_reset=1, no done pulse.
  - abort has priority over a same-cycle handshake.
- Counts are not interpreted or checked. Wrap-around of the counter within a window is passed through as-is.
- Reset asserted mid-operation forces all outputs to their reset values asynchronously. Operation resumes only on a new start.

Decomposition:
- Package edge_sched_pkg holds:
  - the state enum (state_t)
  - localparams for default CW and WIN_W
- One sub-module, edge_sched_timer: a loadable down-counter with a terminal-count flag. It is shared for the CLEAR, WINDOW and SETTLE durations.
- Channel priority-select (next set bit above sel) stays inline.

Test Plan:
- Sweep 1, mask=4'b0101, win_len=100:
  - Stimulus: ch0 toggles every 10 cycles starting low; ch2 held high; res_ready=1.
  - Required: results {ch0, pos=5, neg=5}, then {ch2, pos=0, neg=0}, then a single done pulse.
  - Also check: exactly 2 res_valid handshakes in total, and cnt_reset is high for 2 cycles before each window.
- Backpressure on mask=4'b0011: hold res_ready=0 for 50 cycles. Required: res_valid and all result fields stable throughout; ch1 processing does not begin until the handshake.
- mask=0 start: required done one cycle later, busy never asserted, no res_valid.
- Abort during WINDOW of ch1 in a sweep with mask=4'b1111:
  - Required next cycle: IDLE, busy=0, res_valid=0, cnt_reset=1, no done.
  - A following start sweeps from ch0 normally.
- start asserted in REPORT: ignored, so latched mask/len are unchanged. Separately, win_len=0 gives a 1-cycle window, and a single toggle inside that window gives a count of 1.
- Reset (active-low) mid-SETTLE: all outputs at reset values immediately. A later sweep with mask=4'b1000 returns a correct ch3 result with res_ch=3.
